// File: rtl/my_fuseddiv.sv
// Unsigned 2N-by-N restoring divider: one quotient bit per cycle, MSB first.
// Divide-by-zero finishes at the accept edge with quotient all ones and dz set.
module my_fuseddiv #(
    parameter int BITWIDTH = 32
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    en,
    input  logic [2*BITWIDTH-1:0]   ain,
    input  logic [BITWIDTH-1:0]     bin,
    output logic                    ready,
    output logic                    valid,
    output logic [2*BITWIDTH-1:0]   qout,
    output logic [BITWIDTH-1:0]     rout,
    output logic                    dz
);

    localparam int DW = 2 * BITWIDTH;
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [CW-1:0]          cnt_r;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [DW-1:0]          work_r;
    logic [BITWIDTH-1:0]    div_r;
    logic [BITWIDTH-1:0]    rem_r;
    logic [DW-1:0]          qout_r;
    logic [BITWIDTH-1:0]    rout_r;
    logic                   dz_r;
    logic                   valid_r;

    logic [BITWIDTH:0]      trial_s;
    logic [BITWIDTH-1:0]    rem_next_s;
    logic                   qbit_s;
    logic [DW-1:0]          work_next_s;

    // One restoring step: the stored remainder is always below the divisor, so only the shifted trial needs the extra bit.
    always_comb begin
        trial_s     = {rem_r, work_r[DW-1]};
        rem_next_s  = rem_r;
        qbit_s      = 1'b0;
        if (trial_s >= {1'b0, div_r}) begin
            rem_next_s = trial_s[BITWIDTH-1:0] - div_r;
            qbit_s     = 1'b1;
        end else begin
            rem_next_s = trial_s[BITWIDTH-1:0];
            qbit_s     = 1'b0;
        end
        work_next_s = {work_r[DW-2:0], qbit_s};
    end

    // Next-state decode for the IDLE/BUSY/DONE controller.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    next_state_s = (bin == {BITWIDTH{1'b0}}) ? DONE : BUSY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == {CW{1'b0}}) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = BUSY;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand latch, iteration datapath and registered results.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_r   <= {CW{1'b0}};
            work_r  <= {DW{1'b0}};
            div_r   <= {BITWIDTH{1'b0}};
            rem_r   <= {BITWIDTH{1'b0}};
            qout_r  <= {DW{1'b0}};
            rout_r  <= {BITWIDTH{1'b0}};
            dz_r    <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (en) begin
                        work_r <= ain;
                        div_r  <= bin;
                        rem_r  <= {BITWIDTH{1'b0}};
                        cnt_r  <= CW'(DW - 1);
                        if (bin == {BITWIDTH{1'b0}}) begin
                            qout_r  <= {DW{1'b1}};
                            rout_r  <= ain[BITWIDTH-1:0];
                            dz_r    <= 1'b1;
                            valid_r <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    work_r <= work_next_s;
                    rem_r  <= rem_next_s;
                    cnt_r  <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == {CW{1'b0}}) begin
                        qout_r  <= work_next_s;
                        rout_r  <= rem_next_s;
                        dz_r    <= 1'b0;
                        valid_r <= 1'b1;
                    end
                end
                DONE:    valid_r <= 1'b0;
                default: valid_r <= 1'b0;
            endcase
        end
    end

    assign ready = (state_r == IDLE);
    assign valid = valid_r;
    assign qout  = qout_r;
    assign rout  = rout_r;
    assign dz    = dz_r;

endmodule

// File: tb/tb_my_fuseddiv.sv
// Randomized self-checking bench for my_fuseddiv against a latency/arithmetic model.
module tb_my_fuseddiv;

    logic        clk;
    logic        aresetn;
    logic        en;
    logic [63:0] ain;
    logic [31:0] bin;
    logic        ready;
    logic        valid;
    logic [63:0] qout;
    logic [31:0] rout;
    logic        dz;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    my_fuseddiv #(.BITWIDTH(32)) dut (
        .clk(clk), .aresetn(aresetn), .en(en), .ain(ain), .bin(bin),
        .ready(ready), .valid(valid), .qout(qout), .rout(rout), .dz(dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain division, result appears 64 edges after accept (or at once for bin=0).
    logic        m_ready, m_valid, m_dz;
    logic [63:0] m_q, pend_q;
    logic [31:0] m_r, pend_r;
    int          m_left;
    logic [63:0] m_quo_s, m_rem_s;
    assign m_quo_s = (bin == 32'd0) ? 64'd0 : ain / {32'd0, bin};
    assign m_rem_s = (bin == 32'd0) ? 64'd0 : ain % {32'd0, bin};

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_ready <= 1'b1; m_valid <= 1'b0; m_dz <= 1'b0;
            m_q <= 64'd0; m_r <= 32'd0; m_left <= 0;
            pend_q <= 64'd0; pend_r <= 32'd0;
        end else if (m_valid) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end else if (m_ready) begin
            if (en) begin
                m_ready <= 1'b0;
                if (bin == 32'd0) begin
                    m_valid <= 1'b1; m_q <= {64{1'b1}};
                    m_r <= ain[31:0]; m_dz <= 1'b1;
                end else begin
                    m_left <= 64;
                    pend_q <= m_quo_s;
                    pend_r <= m_rem_s[31:0];
                end
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid <= 1'b1; m_q <= pend_q; m_r <= pend_r; m_dz <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("ready", {63'd0, ready}, {63'd0, m_ready});
        check("valid", {63'd0, valid}, {63'd0, m_valid});
        check("qout",  qout, m_q);
        check("rout",  {32'd0, rout}, {32'd0, m_r});
        check("dz",    {63'd0, dz}, {63'd0, m_dz});
    end

    // Drive one request at a negedge; returns at the negedge after the accept edge with en low.
    task automatic start(input logic [63:0] a, input logic [31:0] b);
        check("ready_before_start", {63'd0, ready}, 64'd1);
        ain = a; bin = b; en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
    endtask

    // Counts rising edges until valid is seen at a negedge; bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (!valid) begin
            n_checks++; n_fail++;
            $display("FAIL wait_valid: got timeout expected valid within 200 cycles");
        end
    endtask

    initial begin
        int n;
        int last_cyc;
        aresetn = 1'b0; en = 1'b0; ain = 64'd0; bin = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", {63'd0, ready}, 64'd1);
        check("rst_valid", {63'd0, valid}, 64'd0);
        check("rst_qout", qout, 64'd0);
        check("rst_rout", {32'd0, rout}, 64'd0);
        aresetn = 1'b1;
        @(negedge clk);

        // 100 / 7
        start(64'd100, 32'd7);
        wait_valid(n);
        check("lat_100_7", 64'(n), 64'd64);
        check("q_100_7", qout, 64'd14);
        check("r_100_7", {32'd0, rout}, 64'd2);
        check("dz_100_7", {63'd0, dz}, 64'd0);
        check("model_q_100_7", m_q, 64'd14);
        @(negedge clk);
        check("ready_after_100_7", {63'd0, ready}, 64'd1);

        // Largest operands
        start(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(n);
        check("q_max", qout, 64'h0000_0001_0000_0001);
        check("r_max", {32'd0, rout}, 64'd0);
        check("model_q_max", m_q, 64'h0000_0001_0000_0001);
        @(negedge clk);

        // Divide by zero
        start(64'd5, 32'd0);
        wait_valid(n);
        check("lat_dz", 64'(n), 64'd0);
        check("q_dz", qout, 64'hFFFF_FFFF_FFFF_FFFF);
        check("r_dz", {32'd0, rout}, 64'd5);
        check("dz_dz", {63'd0, dz}, 64'd1);
        @(negedge clk);
        check("ready_after_dz", {63'd0, ready}, 64'd1);
        check("hold_q_dz", qout, 64'hFFFF_FFFF_FFFF_FFFF);

        // en and operand changes while busy are ignored
        start(64'd1000, 32'd10);
        en = 1'b1; ain = 64'd7; bin = 32'd2;
        repeat (10) @(negedge clk);
        en = 1'b0;
        wait_valid(n);
        check("q_ignore", qout, 64'd100);
        check("r_ignore", {32'd0, rout}, 64'd0);
        check("lat_ignore", 64'(n + 10), 64'd64);
        @(negedge clk);

        // Reset mid-operation, then release coincident with a request
        start(64'd12345, 32'd17);
        repeat (20) @(posedge clk);
        #2 aresetn = 1'b0;
        #1;
        check("abort_valid", {63'd0, valid}, 64'd0);
        check("abort_ready", {63'd0, ready}, 64'd1);
        check("abort_qout", qout, 64'd0);
        check("abort_rout", {32'd0, rout}, 64'd0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1; ain = 64'd0; bin = 32'd3; en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        wait_valid(n);
        check("lat_after_rst", 64'(n), 64'd64);
        check("q_after_rst", qout, 64'd0);
        check("r_after_rst", {32'd0, rout}, 64'd0);
        @(negedge clk);

        // Back-to-back random operations with en held high
        last_cyc = 0;
        ain = {$urandom, $urandom};
        bin = $urandom_range(32'hFFFF_FFFF, 32'd1);
        en  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            wait_valid(n);
            if (i > 0) check("interval", 64'(cyc - last_cyc), 64'd66);
            last_cyc = cyc;
            if (i == 31) begin
                en = 1'b0;
            end else begin
                ain = {$urandom, $urandom};
                if (i % 3 == 0) bin = $urandom_range(32'd16, 32'd1);
                else            bin = $urandom_range(32'hFFFF_FFFF, 32'd1);
            end
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
